// File: rtl/mux_scan_sequencer.sv
// Scans a NUM_INPUTS-way mux selector 0..NUM_INPUTS-1 and streams the selected words over valid/ready.
// Optional build macro MUXSEQ_RELU_EN clamps negative (signed) mux words to zero before capture.
module mux_scan_sequencer #(
   parameter int INPUT_DATA_WIDTH = 8,
   parameter int BITWIDTH_SEL     = 9,
   parameter int NUM_INPUTS       = 36
) (
   input  logic                        MUXSEQ_CLOCK_50,
   input  logic                        MUXSEQ_RESET_InHigh,
   input  logic                        MUXSEQ_Start_In,
   input  logic                        MUXSEQ_Abort_In,
   input  logic [INPUT_DATA_WIDTH-1:0] MUXSEQ_MuxData_In,
   input  logic                        MUXSEQ_Ready_In,
   output logic [BITWIDTH_SEL-1:0]     MUXSEQ_Selector_Out,
   output logic [INPUT_DATA_WIDTH-1:0] MUXSEQ_Data_Out,
   output logic                        MUXSEQ_Valid_Out,
   output logic                        MUXSEQ_Last_Out,
   output logic                        MUXSEQ_Busy_Out,
   output logic                        MUXSEQ_Done_Out
);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

   localparam logic [BITWIDTH_SEL-1:0] LAST_SEL = BITWIDTH_SEL'(NUM_INPUTS - 1);

   state_t                        state, state_nxt;
   logic [BITWIDTH_SEL-1:0]       sel_q, sel_nxt;
   logic [INPUT_DATA_WIDTH-1:0]   data_q, data_nxt;
   logic [INPUT_DATA_WIDTH-1:0]   cap_data;
   logic                          valid_q, valid_nxt;
   logic                          last_q, last_nxt;
   logic                          done_q, done_nxt;
   logic                          advance;

`ifdef MUXSEQ_RELU_EN
   assign cap_data = MUXSEQ_MuxData_In[INPUT_DATA_WIDTH-1] ? '0 : MUXSEQ_MuxData_In;
`else
   assign cap_data = MUXSEQ_MuxData_In;
`endif

   // Output register is free when empty or being drained this edge
   assign advance = !valid_q || MUXSEQ_Ready_In;

   always_ff @(posedge MUXSEQ_CLOCK_50 or posedge MUXSEQ_RESET_InHigh) begin
      if (MUXSEQ_RESET_InHigh) begin
         state   <= IDLE;
         sel_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         sel_q   <= sel_nxt;
         data_q  <= data_nxt;
         valid_q <= valid_nxt;
         last_q  <= last_nxt;
         done_q  <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      sel_nxt   = sel_q;
      data_nxt  = data_q;
      valid_nxt = valid_q;
      last_nxt  = last_q;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            sel_nxt = '0;
            if (MUXSEQ_Start_In) state_nxt = SCAN;
         end
         SCAN: begin
            if (MUXSEQ_Abort_In) begin
               // Abort wins over any transfer on this edge; the beat is dropped
               valid_nxt = 1'b0;
               last_nxt  = 1'b0;
               sel_nxt   = '0;
               state_nxt = IDLE;
            end else if (advance) begin
               data_nxt  = cap_data;
               valid_nxt = 1'b1;
               last_nxt  = (sel_q == LAST_SEL);
               if (sel_q == LAST_SEL) state_nxt = DRAIN;
               else                   sel_nxt   = sel_q + BITWIDTH_SEL'(1);
            end
         end
         DRAIN: begin
            if (MUXSEQ_Abort_In) begin
               valid_nxt = 1'b0;
               last_nxt  = 1'b0;
               sel_nxt   = '0;
               state_nxt = IDLE;
            end else if (valid_q && MUXSEQ_Ready_In) begin
               valid_nxt = 1'b0;
               last_nxt  = 1'b0;
               sel_nxt   = '0;
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            valid_nxt = 1'b0;
            last_nxt  = 1'b0;
            sel_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   assign MUXSEQ_Selector_Out = sel_q;
   assign MUXSEQ_Data_Out     = data_q;
   assign MUXSEQ_Valid_Out    = valid_q;
   assign MUXSEQ_Last_Out     = last_q;
   assign MUXSEQ_Done_Out     = done_q;
   assign MUXSEQ_Busy_Out     = (state != IDLE);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: a 36-entry mux model with In[i] = i+1 feeds the DUT.
module tb_mux_scan_sequencer;
   localparam int W  = 8;
   localparam int SW = 9;
   localparam int N  = 36;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          ready = 1'b1;
   logic [W-1:0]  mux_data, data;
   logic [SW-1:0] sel;
   logic          valid, last, busy, done;
   logic [W-1:0]  mem [N];

   always #5 clk = ~clk;

   assign mux_data = (int'(sel) < N) ? mem[sel] : '0;

   mux_scan_sequencer #(.INPUT_DATA_WIDTH(W), .BITWIDTH_SEL(SW), .NUM_INPUTS(N)) dut (
      .MUXSEQ_CLOCK_50    (clk),
      .MUXSEQ_RESET_InHigh(rst),
      .MUXSEQ_Start_In    (start),
      .MUXSEQ_Abort_In    (abort),
      .MUXSEQ_MuxData_In  (mux_data),
      .MUXSEQ_Ready_In    (ready),
      .MUXSEQ_Selector_Out(sel),
      .MUXSEQ_Data_Out    (data),
      .MUXSEQ_Valid_Out   (valid),
      .MUXSEQ_Last_Out    (last),
      .MUXSEQ_Busy_Out    (busy),
      .MUXSEQ_Done_Out    (done)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Negedge monitor: collects transferred beats, counts done pulses, checks stall stability
   logic [W-1:0]  q_data [$];
   bit            q_last [$];
   int            done_cnt = 0;
   bit            mon_en = 0;
   bit            pv = 0, pr = 0;
   logic [W-1:0]  pd;
   logic [SW-1:0] ps;

   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if (valid && ready && !abort) begin
            q_data.push_back(data);
            q_last.push_back(last);
         end
         if (done) done_cnt++;
         if (pv && !pr) begin
            chk("stall_data", 32'(data), 32'(pd));
            chk("stall_sel", 32'(sel), 32'(ps));
            chk("stall_valid", 32'(valid), 32'd1);
         end
      end
      pv = valid && !rst;
      pr = ready;
      pd = data;
      ps = sel;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_mon();
      q_data.delete();
      q_last.delete();
      done_cnt = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // mode 0: ready held high; mode 1: ready pattern 1,0,0,1
   task automatic wait_done(input int mode, input int budget, output int cyc);
      bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      cyc = 0;
      forever begin
         if (mode == 1) ready = pat[cyc % 4];
         tick();
         cyc++;
         if (done) break;
         if (cyc >= budget) begin
            chk("done_timeout", 32'd0, 32'd1);
            break;
         end
      end
      ready = 1'b1;
   endtask

   task automatic wait_beats(input int n);
      int b = 0;
      while (q_data.size() < n && b < 200) begin
         tick();
         b++;
      end
      if (q_data.size() < n) chk("beats_timeout", 32'(q_data.size()), 32'(n));
   endtask

   task automatic check_seq(input string tag, input int n);
      chk({tag, "_count"}, 32'(q_data.size()), 32'(n));
      for (int i = 0; i < n && i < q_data.size(); i++) begin
         chk({tag, "_data"}, 32'(q_data[i]), 32'((i % N) + 1));
         chk({tag, "_last"}, 32'(q_last[i]), 32'((i % N) == N - 1));
      end
   endtask

   initial begin
      int cyc;
      for (int i = 0; i < N; i++) mem[i] = W'(i + 1);

      // reset state
      repeat (3) tick();
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_data", 32'(data), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_last", 32'(last), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      rst = 1'b0;
      tick();
      mon_en = 1;

      // full scan, ready high
      clear_mon();
      pulse_start();
      chk("lat_busy", 32'(busy), 32'd1);
      chk("lat_valid", 32'(valid), 32'd0);
      tick();
      chk("first_valid", 32'(valid), 32'd1);
      chk("first_data", 32'(data), 32'd1);
      chk("first_sel", 32'(sel), 32'd1);
      wait_done(0, 200, cyc);
      chk("done_cycle", 32'(cyc), 32'd36);
      tick();
      chk("done_width", 32'(done), 32'd0);
      chk("idle_sel", 32'(sel), 32'd0);
      chk("idle_valid", 32'(valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      check_seq("ready_high", N);
      chk("ready_high_done", 32'(done_cnt), 32'd1);

      // backpressure toggling
      clear_mon();
      pulse_start();
      wait_done(1, 400, cyc);
      tick();
      check_seq("ready_toggle", N);
      chk("ready_toggle_done", 32'(done_cnt), 32'd1);

      // async reset mid-scan
      clear_mon();
      pulse_start();
      wait_beats(10);
      rst = 1'b1;
      #1;
      chk("arst_valid", 32'(valid), 32'd0);
      chk("arst_sel", 32'(sel), 32'd0);
      chk("arst_data", 32'(data), 32'd0);
      chk("arst_last", 32'(last), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      clear_mon();
      pulse_start();
      wait_done(0, 200, cyc);
      tick();
      check_seq("after_reset", N);

      // abort at beat 20, with an ignored start earlier
      clear_mon();
      pulse_start();
      repeat (5) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_beats(20);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_valid", 32'(valid), 32'd0);
      chk("abort_sel", 32'(sel), 32'd0);
      chk("abort_last", 32'(last), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      repeat (5) tick();
      chk("abort_no_done", 32'(done_cnt), 32'd0);
      chk("abort_stays_idle", 32'(busy), 32'd0);
      check_seq("abort", 20);

      // abort in idle is harmless
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("idle_abort_busy", 32'(busy), 32'd0);

      // back-to-back scans: start in the done cycle
      clear_mon();
      pulse_start();
      wait_done(0, 200, cyc);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("b2b_busy", 32'(busy), 32'd1);
      wait_done(0, 200, cyc);
      chk("b2b_cycle", 32'(cyc), 32'd37);
      tick();
      check_seq("b2b", 2 * N);
      chk("b2b_done", 32'(done_cnt), 32'd2);

      // ReLU boundary words
      mem[5] = 8'hF0;
      mem[6] = 8'h7F;
      clear_mon();
      pulse_start();
      wait_done(0, 200, cyc);
      tick();
      chk("relu_count", 32'(q_data.size()), 32'(N));
      if (q_data.size() >= 7) begin
`ifdef MUXSEQ_RELU_EN
         chk("relu_neg", 32'(q_data[5]), 32'h00);
`else
         chk("relu_neg", 32'(q_data[5]), 32'hF0);
`endif
         chk("relu_pos", 32'(q_data[6]), 32'h7F);
      end
      mem[5] = 8'd6;
      mem[6] = 8'd7;

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
